satd_hadamard4x4: RTL and testbench
===================================

# satd_hadamard4x4

Downstream stage of the per-pixel difference engine: consumes the signed 9-bit residual stream (ORG − CUR), one difference per cycle, and groups every 16 accepted samples into a 4×4 block in raster order. It applies a 2-D 4-point Hadamard transform to each block, sums the absolute coefficients, and emits one unnormalised SATD value per block. Blocks may arrive back-to-back with no stall.

## Interface
- `DIFF_W`, default 9: signed width of the input difference.
- `SATD_W`, default 16: width of the unsigned SATD output. The minimum legal value is `DIFF_W + 7`.
- `clk`, input, 1: the single clock. Everything samples on the rising edge.
- `rst`, input, 1: reset, **asynchronous and active-high**.
- `diff_valid`, input, 1: `diff` is valid this cycle.
- `diff`, input, `DIFF_W` signed: residual sample, range −255..255.
- `blk_start`, input, 1: qualified by `diff_valid`. Marks the current sample as element (0,0) of a new block.
- `satd_valid`, output, 1: one-cycle pulse when `satd` is updated.
- `satd`, output, `SATD_W` unsigned: sum of |coefficients| for the last completed block.

## Operation
- **Reset values:**
  - `satd` = 0, `satd_valid` = 0.
  - Element counter = 0, row store = 0, pipeline valid flags = 0.
- **Element counter:**
  - 4 bits: row = [3:2], column = [1:0].
  - Advances only on `diff_valid`. Idle cycles between samples are allowed anywhere.
- **`blk_start`:** when asserted with `diff_valid`, the counter is forced to 0 before the sample is placed.
  - Any partial block is silently discarded.
  - No `satd_valid` is produced for the discarded block.
- **Row stage:**
  - Columns 0–2 of the current row are held in a 3-entry row buffer.
  - When the column-3 sample arrives, a 4-point Hadamard is computed combinationally from the buffer plus the incoming sample.
  - The result is written to `row_store[row]`.
- **Hadamard kernel:** Sylvester H4, rows [1 1 1 1], [1 −1 1 −1], [1 1 −1 −1], [1 −1 −1 1]. Implemented as a 2-level butterfly.
- **Block completion:** the write of `row_store[3]` raises `blk_done`.
- **Column stage:** on the edge after `blk_done`, all 4 columns of `row_store` go through H4. The 16 coefficients are registered into `coef[]` and `coef_valid` is set.
- **Sum stage:** on the next edge:
  - the sum of |`coef[i]`| over all 16 coefficients is registered into `satd`;
  - `satd_valid` is asserted for exactly that one cycle.
- **Widths:**
  - Row results: `DIFF_W` + 2 signed (11 bits at defaults).
  - Coefficients: `DIFF_W` + 4 signed (13 bits).
  - Absolute values are unsigned and the adder tree is `SATD_W` wide. Overflow cannot occur.
  - No division or normalisation by 2.
- **Overwrite safety:** the row store may be overwritten by the next block from the edge after `blk_done` onward. The column stage has already captured it, so no double buffer is needed.
- **Output hold:** `satd` holds its value between pulses.
- **No backpressure:** the consumer must accept `satd` during the `satd_valid` cycle.

## Timing
- Sustained throughput: one sample per cycle, one SATD per 16 samples.
- Latency: if the 16th sample is sampled at edge N, `satd` and `satd_valid` update at edge N+2, so they are high in cycle N+2..N+3.
- Back-to-back blocks: `satd_valid` pulses are 16 cycles apart, with no bubbles.
- **`rst` asserted mid-block or mid-pipeline:**
  - All in-flight work is lost and `satd_valid` stays 0.
  - After `rst` deasserts, the first valid sample is element (0,0).
- **`blk_start` on the sample after a 16th sample:** behaves as a normal block start. The previous block's SATD is still produced.

## Structure
- Package `satd_pkg` holds the shared constants:
  - `DIFF_W` = 9, `ROW_W` = 11, `COEF_W` = 13, `SATD_W` = 16;
  - `BLK_DIM` = 4, `BLK_N` = 16;
  - typedefs `diff_t`, `row_coef_t`, `coef_t`, `satd_t`.
- Sub-module `hadamard4`: combinational, parameter `IN_W`, 4 signed in, 4 signed `IN_W`+2 out.
  - Instantiated once for the row stage and four times for the column stage.
- The top module holds:
  - the element counter;
  - the row buffer;
  - the 4×4 row store;
  - the `coef` registers;
  - the abs/adder tree;
  - the two pipeline valid flags.

## Test plan
- 16 zeros → `satd_valid` pulse with `satd` = 0, exactly 2 edges after the last sample.
- Sample (0,0) = 1, the other 15 = 0 → `satd` = 16.
- All 16 = 255 → `satd` = 4080; all 16 = −255 → `satd` = 4080; checkerboard ±255 → `satd` = 4080.
- Two blocks back-to-back (all 1s, then the single-1 pattern) → `satd` = 16 then 16, with pulses exactly 16 cycles apart. Repeat with random idle gaps in `diff_valid` → identical values.
- 7 samples of 100, then `blk_start` with a block of all 1s → exactly one pulse, with `satd` = 16.
- `rst` after 10 samples, then a fresh block of all 2s → no pulse for the aborted block; then `satd` = 32.

Source files
------------

// File: rtl/satd_hadamard4x4_pkg.sv
// rtl/satd_hadamard4x4_pkg.sv - shared constants and types for the 4x4 Hadamard SATD block
package satd_pkg;

  localparam int DIFF_W  = 9;
  localparam int ROW_W   = DIFF_W + 2;
  localparam int COEF_W  = DIFF_W + 4;
  localparam int SATD_W  = 16;
  localparam int BLK_DIM = 4;
  localparam int BLK_N   = BLK_DIM * BLK_DIM;

  typedef logic signed [DIFF_W-1:0] diff_t;
  typedef logic signed [ROW_W-1:0]  row_coef_t;
  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic        [SATD_W-1:0] satd_t;

endpackage

// File: rtl/satd_hadamard4x4_if.sv
// rtl/satd_hadamard4x4_if.sv - residual input stream and SATD result port bundle
interface satd_hadamard4x4_if #(
  parameter int DIFF_W = satd_pkg::DIFF_W,
  parameter int SATD_W = satd_pkg::SATD_W
);

  logic                     diff_valid;
  logic signed [DIFF_W-1:0] diff;
  logic                     blk_start;
  logic                     satd_valid;
  logic        [SATD_W-1:0] satd;

  // Producer of residuals / consumer of SATD results
  modport master (
    output diff_valid, diff, blk_start,
    input  satd_valid, satd
  );

  // The SATD engine itself
  modport slave (
    input  diff_valid, diff, blk_start,
    output satd_valid, satd
  );

endinterface

// File: rtl/satd_hadamard4x4_hadamard4.sv
// rtl/satd_hadamard4x4_hadamard4.sv - combinational 4-point Sylvester Hadamard butterfly
module hadamard4 #(
  parameter int IN_W = satd_pkg::DIFF_W
) (
  input  logic signed [IN_W-1:0] x0,
  input  logic signed [IN_W-1:0] x1,
  input  logic signed [IN_W-1:0] x2,
  input  logic signed [IN_W-1:0] x3,
  output logic signed [IN_W+1:0] y0,
  output logic signed [IN_W+1:0] y1,
  output logic signed [IN_W+1:0] y2,
  output logic signed [IN_W+1:0] y3
);

  logic signed [IN_W:0] a0, a1, a2, a3;

  // Two butterfly levels; outputs follow rows [1 1 1 1],[1 -1 1 -1],[1 1 -1 -1],[1 -1 -1 1]
  always_comb begin
    a0 = (IN_W+1)'(x0) + (IN_W+1)'(x1);
    a1 = (IN_W+1)'(x0) - (IN_W+1)'(x1);
    a2 = (IN_W+1)'(x2) + (IN_W+1)'(x3);
    a3 = (IN_W+1)'(x2) - (IN_W+1)'(x3);
    y0 = (IN_W+2)'(a0) + (IN_W+2)'(a2);
    y1 = (IN_W+2)'(a1) + (IN_W+2)'(a3);
    y2 = (IN_W+2)'(a0) - (IN_W+2)'(a2);
    y3 = (IN_W+2)'(a1) - (IN_W+2)'(a3);
  end

endmodule

// File: rtl/satd_hadamard4x4.sv
// rtl/satd_hadamard4x4.sv - streaming 4x4 2-D Hadamard SATD, one result per 16 residuals
module satd_hadamard4x4
  import satd_pkg::*;
#(
  parameter int DIFF_W = satd_pkg::DIFF_W,
  parameter int SATD_W = satd_pkg::SATD_W
) (
  input  logic                clk,
  input  logic                rst,
  satd_hadamard4x4_if.slave   bus
);

  localparam int ROW_BITS  = DIFF_W + 2;
  localparam int COEF_BITS = DIFF_W + 4;

  // Element counter: [3:2] = row, [1:0] = column within the block
  logic [3:0]                 cnt_q, cnt_d;
  logic [3:0]                 idx;
  logic signed [DIFF_W-1:0]   rowbuf_q [3];
  logic signed [DIFF_W-1:0]   rowbuf_d [3];
  logic signed [ROW_BITS-1:0] row_store_q [BLK_DIM][BLK_DIM];
  logic signed [ROW_BITS-1:0] row_store_d [BLK_DIM][BLK_DIM];
  logic                       blk_done_q, blk_done_d;
  logic signed [COEF_BITS-1:0] coef_q [BLK_N];
  logic signed [COEF_BITS-1:0] coef_d [BLK_N];
  logic                       coef_valid_q, coef_valid_d;
  logic [SATD_W-1:0]          satd_q, satd_d;
  logic                       satd_valid_q, satd_valid_d;

  logic signed [ROW_BITS-1:0]  row_h [BLK_DIM];
  logic signed [COEF_BITS-1:0] col_h [BLK_DIM][BLK_DIM];
  logic [COEF_BITS-1:0]        mag;
  logic [SATD_W-1:0]           satd_sum;

  // Row transform: three buffered columns plus the incoming column-3 sample
  hadamard4 #(.IN_W(DIFF_W)) u_row (
    .x0(rowbuf_q[0]), .x1(rowbuf_q[1]), .x2(rowbuf_q[2]), .x3(bus.diff),
    .y0(row_h[0]),    .y1(row_h[1]),    .y2(row_h[2]),    .y3(row_h[3])
  );

  // Column transform: one butterfly per column of the completed row store
  for (genvar c = 0; c < BLK_DIM; c++) begin : g_col
    hadamard4 #(.IN_W(ROW_BITS)) u_col (
      .x0(row_store_q[0][c]), .x1(row_store_q[1][c]),
      .x2(row_store_q[2][c]), .x3(row_store_q[3][c]),
      .y0(col_h[0][c]), .y1(col_h[1][c]), .y2(col_h[2][c]), .y3(col_h[3][c])
    );
  end

  // Next-state: sample placement, row/column stage capture and the |coef| adder tree
  always_comb begin
    cnt_d        = cnt_q;
    rowbuf_d     = rowbuf_q;
    row_store_d  = row_store_q;
    blk_done_d   = 1'b0;
    coef_d       = coef_q;
    coef_valid_d = blk_done_q;
    satd_d       = satd_q;
    satd_valid_d = coef_valid_q;
    mag          = '0;
    satd_sum     = '0;

    // blk_start forces this sample to (0,0), dropping any partial block
    idx = bus.blk_start ? 4'd0 : cnt_q;

    if (bus.diff_valid) begin
      cnt_d = idx + 4'd1;
      case (idx[1:0])
        2'd0:    rowbuf_d[0] = bus.diff;
        2'd1:    rowbuf_d[1] = bus.diff;
        2'd2:    rowbuf_d[2] = bus.diff;
        default: begin
          for (int k = 0; k < BLK_DIM; k++) begin
            row_store_d[idx[3:2]][k] = row_h[k];
          end
          blk_done_d = (idx[3:2] == 2'd3);
        end
      endcase
    end

    // Row store is captured the edge after blk_done, so it may be overwritten right after
    if (blk_done_q) begin
      for (int r = 0; r < BLK_DIM; r++) begin
        for (int c = 0; c < BLK_DIM; c++) begin
          coef_d[r*BLK_DIM + c] = col_h[r][c];
        end
      end
    end

    for (int i = 0; i < BLK_N; i++) begin
      mag      = coef_q[i][COEF_BITS-1] ? -coef_q[i] : coef_q[i];
      satd_sum = satd_sum + SATD_W'(mag);
    end
    if (coef_valid_q) begin
      satd_d = satd_sum;
    end
  end

  // State registers; reset drops every in-flight block
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      rowbuf_q     <= '{default: '0};
      row_store_q  <= '{default: '{default: '0}};
      blk_done_q   <= 1'b0;
      coef_q       <= '{default: '0};
      coef_valid_q <= 1'b0;
      satd_q       <= '0;
      satd_valid_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      rowbuf_q     <= rowbuf_d;
      row_store_q  <= row_store_d;
      blk_done_q   <= blk_done_d;
      coef_q       <= coef_d;
      coef_valid_q <= coef_valid_d;
      satd_q       <= satd_d;
      satd_valid_q <= satd_valid_d;
    end
  end

  assign bus.satd       = satd_q;
  assign bus.satd_valid = satd_valid_q;

endmodule

// File: tb/tb_satd_hadamard4x4.sv
// tb/tb_satd_hadamard4x4.sv - self-checking bench for satd_hadamard4x4
module tb_satd_hadamard4x4;
  import satd_pkg::*;

  logic clk;
  logic rst;
  int   cyc;
  int   total;
  int   bad;

  int   blk[$];
  int   exp_val[$];
  int   exp_cyc[$];
  int   got_val[$];
  int   got_cyc[$];

  satd_hadamard4x4_if bus ();

  satd_hadamard4x4 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Collect every result pulse with the edge count at which it appeared
  always @(negedge clk) begin
    if (bus.satd_valid === 1'b1) begin
      got_val.push_back(int'(bus.satd));
      got_cyc.push_back(cyc);
    end
  end

  // Sylvester H4 entry: (-1)^popcount(i & j)
  function automatic int hsign(input int i, input int j);
    int p;
    p = (i & j);
    p = (p & 1) + ((p >> 1) & 1);
    return (p % 2 == 1) ? -1 : 1;
  endfunction

  // SATD as the matrix sum |H X H^T| over a raster-ordered 16-sample block
  function automatic int satd_ref(input int b[$]);
    int s;
    int y;
    s = 0;
    for (int u = 0; u < 4; u++) begin
      for (int v = 0; v < 4; v++) begin
        y = 0;
        for (int r = 0; r < 4; r++) begin
          for (int c = 0; c < 4; c++) begin
            y += hsign(u, r) * b[r*4 + c] * hsign(v, c);
          end
        end
        s += (y < 0) ? -y : y;
      end
    end
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic put(input int d, input bit start);
    @(negedge clk);
    bus.diff_valid = 1'b1;
    bus.diff       = DIFF_W'(d);
    bus.blk_start  = start;
    if (start) blk.delete();
    blk.push_back(d);
    if (blk.size() == 16) begin
      exp_val.push_back(satd_ref(blk));
      exp_cyc.push_back(cyc + 3);
      blk.delete();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.diff_valid = 1'b0;
      bus.blk_start  = 1'b0;
      bus.diff       = '0;
    end
  endtask

  task automatic put_block(input int kind, input bit start, input bit gaps);
    int v;
    for (int i = 0; i < 16; i++) begin
      case (kind)
        0:       v = 0;
        1:       v = (i == 0) ? 1 : 0;
        2:       v = 1;
        3:       v = 255;
        4:       v = -255;
        5:       v = (((i >> 2) + (i & 3)) % 2 == 0) ? 255 : -255;
        6:       v = 2;
        default: v = int'($urandom_range(0, 510)) - 255;
      endcase
      put(v, start && (i == 0));
      if (gaps && ($urandom_range(0, 2) == 0)) idle(int'($urandom_range(1, 3)));
    end
  endtask

  // Drain the pipeline, then compare pulses against the model and optional literal plan
  task automatic flush_check(input string tag, input int n, input int p0, input int p1,
                             input bit gap16);
    int m;
    idle(5);
    chk({tag, " count"}, got_val.size(), exp_val.size());
    if (n >= 0) chk({tag, " plan count"}, got_val.size(), n);
    m = (got_val.size() < exp_val.size()) ? got_val.size() : exp_val.size();
    for (int i = 0; i < m; i++) begin
      chk({tag, " satd"}, got_val[i], exp_val[i]);
      chk({tag, " edge"}, got_cyc[i], exp_cyc[i]);
    end
    if (n >= 1 && got_val.size() >= 1) chk({tag, " plan0"}, got_val[0], p0);
    if (n >= 2 && got_val.size() >= 2) chk({tag, " plan1"}, got_val[1], p1);
    if (gap16 && got_cyc.size() >= 2) chk({tag, " spacing"}, got_cyc[1] - got_cyc[0], 16);
    if (got_val.size() >= 1) chk({tag, " hold"}, bus.satd, got_val[got_val.size()-1]);
    got_val.delete();
    got_cyc.delete();
    exp_val.delete();
    exp_cyc.delete();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.diff_valid = 1'b0;
    bus.blk_start  = 1'b0;
    bus.diff       = '0;
    repeat (3) @(negedge clk);
    chk("reset satd", bus.satd, 0);
    chk("reset valid", bus.satd_valid, 0);
    rst = 1'b0;
    idle(2);

    put_block(0, 1'b0, 1'b0);
    flush_check("zeros", 1, 0, 0, 1'b0);
    put_block(1, 1'b0, 1'b0);
    flush_check("single", 1, 16, 0, 1'b0);
    put_block(3, 1'b0, 1'b0);
    flush_check("pos255", 1, 4080, 0, 1'b0);
    put_block(4, 1'b0, 1'b0);
    flush_check("neg255", 1, 4080, 0, 1'b0);
    put_block(5, 1'b0, 1'b0);
    flush_check("checker", 1, 4080, 0, 1'b0);

    put_block(2, 1'b0, 1'b0);
    put_block(1, 1'b0, 1'b0);
    flush_check("b2b", 2, 16, 16, 1'b1);
    put_block(2, 1'b0, 1'b1);
    put_block(1, 1'b0, 1'b1);
    flush_check("b2b gaps", 2, 16, 16, 1'b0);

    for (int i = 0; i < 7; i++) put(100, 1'b0);
    put_block(2, 1'b1, 1'b0);
    flush_check("restart", 1, 16, 0, 1'b0);

    put_block(3, 1'b1, 1'b0);
    put_block(5, 1'b1, 1'b0);
    flush_check("start after 16th", 2, 4080, 4080, 1'b1);

    for (int i = 0; i < 10; i++) put(3, i == 0);
    @(negedge clk);
    rst = 1'b1;
    bus.diff_valid = 1'b0;
    bus.blk_start  = 1'b0;
    blk.delete();
    @(negedge clk);
    chk("midreset satd", bus.satd, 0);
    chk("midreset valid", bus.satd_valid, 0);
    rst = 1'b0;
    put_block(6, 1'b0, 1'b0);
    flush_check("after reset", 1, 32, 0, 1'b0);

    for (int b = 0; b < 25; b++) begin
      if ($urandom_range(0, 4) == 0) begin
        for (int k = 0; k < int'($urandom_range(1, 12)); k++) begin
          put(int'($urandom_range(0, 510)) - 255, k == 0);
        end
      end
      put_block(7, $urandom_range(0, 1) == 1, 1'b1);
    end
    flush_check("random", -1, 0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
